// File: rtl/map_port_arbiter_pkg.sv
// rtl/map_port_arbiter_pkg.sv - tile-map geometry, types and address range helper
package map_port_arbiter_pkg;

    localparam int MAP_W    = 32;
    localparam int MAP_H    = 36;
    localparam int TILE_W   = 4;
    localparam int MAP_SIZE = MAP_W * MAP_H;
    localparam int ADDR_W   = $clog2(MAP_SIZE);

    typedef logic [ADDR_W-1:0] map_addr_t;
    typedef logic [TILE_W-1:0] tile_t;

    localparam tile_t TILE_EMPTY = '0;

    // One extra bit so the limit itself is representable in the compare.
    function automatic logic addr_in_range(input map_addr_t addr);
        return {1'b0, addr} < (ADDR_W + 1)'(MAP_SIZE);
    endfunction

endpackage

// File: rtl/map_tile_ram.sv
// rtl/map_tile_ram.sv - single-port read-first tile RAM with registered output
module map_tile_ram
    import map_port_arbiter_pkg::*;
(
    input  logic      clk_i,
    input  logic      en_i,
    input  logic      we_i,
    input  map_addr_t addr_i,
    input  tile_t     wdata_i,
    output tile_t     rdata_o
);

    tile_t mem_q [MAP_SIZE];
    tile_t rdata_q;

    // Read-first: the old tile is captured on the same edge that writes the new one.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/map_port_arbiter.sv
// rtl/map_port_arbiter.sv - shares the tile RAM port between display (priority) and round-robin game requesters
module map_port_arbiter
    import map_port_arbiter_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic                     vga_pix_clk,
    input  logic                     rst,
    input  logic                     disp_stb,
    input  logic [ADDR_W-1:0]        disp_addr,
    output logic [TILE_W-1:0]        disp_data,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ-1:0]         req_we,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*TILE_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [TILE_W-1:0]        rsp_data,
    output logic                     rsp_err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    map_addr_t addr_a  [N_REQ];
    tile_t     wdata_a [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_a[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = req_wdata[g*TILE_W +: TILE_W];
    end

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic             disp_pend_q, disp_pend_d;
    logic             disp_oor_q, disp_oor_d;
    tile_t            disp_hold_q, disp_hold_d;

    logic [N_REQ-1:0] grant;
    logic [PTR_W-1:0] gnt_idx;
    logic             gnt_any;
    logic [PTR_W:0]   cand;

    // Rotating priority search starting at rr_ptr; display and reset suppress all grants.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        if (!rst && !disp_stb) begin
            for (int k = 0; k < N_REQ; k++) begin
                cand = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
                if (cand >= (PTR_W + 1)'(N_REQ)) begin
                    cand = cand - (PTR_W + 1)'(N_REQ);
                end
                if (!gnt_any && req_valid[cand[PTR_W-1:0]]) begin
                    gnt_any                 = 1'b1;
                    gnt_idx                 = cand[PTR_W-1:0];
                    grant[cand[PTR_W-1:0]]  = 1'b1;
                end
            end
        end
    end

    assign req_ready = grant;

    logic      gnt_in_range;
    logic      disp_in_range;
    logic      ram_en;
    logic      ram_we;
    map_addr_t ram_addr;
    tile_t     ram_wdata;
    tile_t     ram_rdata;

    assign gnt_in_range  = addr_in_range(addr_a[gnt_idx]);
    assign disp_in_range = addr_in_range(disp_addr);

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (disp_stb && !rst) begin
            ram_en   = disp_in_range;
            ram_addr = disp_addr;
        end else if (gnt_any && gnt_in_range) begin
            ram_en    = 1'b1;
            ram_we    = req_we[gnt_idx];
            ram_addr  = addr_a[gnt_idx];
            ram_wdata = wdata_a[gnt_idx];
        end
    end

    map_tile_ram u_ram (
        .clk_i   (vga_pix_clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // disp_data follows the RAM only in the cycle after a display read, otherwise holds.
    assign disp_data = disp_pend_q ? (disp_oor_q ? TILE_EMPTY : ram_rdata) : disp_hold_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = (|rsp_valid_q && !rsp_err_q) ? ram_rdata : TILE_EMPTY;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        if (gnt_any) begin
            rr_ptr_d = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
        rsp_valid_d = grant;
        rsp_err_d   = gnt_any && !gnt_in_range;
        disp_pend_d = disp_stb;
        disp_oor_d  = !disp_in_range;
        disp_hold_d = disp_data;
    end

    always_ff @(posedge vga_pix_clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            disp_pend_q <= 1'b0;
            disp_oor_q  <= 1'b0;
            disp_hold_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            disp_pend_q <= disp_pend_d;
            disp_oor_q  <= disp_oor_d;
            disp_hold_q <= disp_hold_d;
        end
    end

endmodule
